// File: rtl/vc_fifo.sv
// vc_fifo: per-VC circular buffers behind shared write/read ports; VC_FIFO_FWFT_EN selects first-word-fall-through reads
module vc_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH_WIDTH = 2,
  parameter int NUM_VC           = 2,
  parameter int ID               = 0,
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CNT_W = FIFO_DEPTH_WIDTH + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [VC_W-1:0]         wr_vc_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    rd_en_i,
  input  logic [VC_W-1:0]         rd_vc_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  output logic [NUM_VC-1:0]       full_o,
  output logic [NUM_VC-1:0]       empty_o,
  output logic [NUM_VC*CNT_W-1:0] count_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);
  localparam int DEPTH = 2 ** FIFO_DEPTH_WIDTH;
  localparam logic [VC_W:0] NV = (VC_W+1)'(NUM_VC);

  if (NUM_VC < 1 || ID < 0) begin : g_param_check
    $error("vc_fifo: NUM_VC must be >= 1 and ID non-negative");
  end

  logic [DATA_WIDTH-1:0]       mem [NUM_VC][DEPTH];
  logic [FIFO_DEPTH_WIDTH-1:0] wr_ptr [NUM_VC];
  logic [FIFO_DEPTH_WIDTH-1:0] rd_ptr [NUM_VC];
  logic [CNT_W-1:0]            cnt [NUM_VC];
  logic [NUM_VC-1:0]           wr_sel, rd_sel;
  logic                        wr_in, rd_in, wr_ok, rd_ok;

  assign wr_in = {1'b0, wr_vc_i} < NV;
  assign rd_in = {1'b0, rd_vc_i} < NV;
  assign rd_ok = rd_en_i && rd_in && !empty_o[rd_vc_i];
  // a full VC still takes a write when the same VC is popped in this cycle
  assign wr_ok = wr_en_i && wr_in && (!full_o[wr_vc_i] || (rd_ok && rd_vc_i == wr_vc_i));

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign full_o[v]                 = cnt[v] == CNT_W'(DEPTH);
    assign empty_o[v]                = cnt[v] == '0;
    assign count_o[v*CNT_W +: CNT_W] = cnt[v];
    assign wr_sel[v]                 = wr_ok && wr_vc_i == VC_W'(v);
    assign rd_sel[v]                 = rd_ok && rd_vc_i == VC_W'(v);
  end

  // pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
    else
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= wr_ptr[v] + FIFO_DEPTH_WIDTH'(wr_sel[v]);
        rd_ptr[v] <= rd_ptr[v] + FIFO_DEPTH_WIDTH'(rd_sel[v]);
        cnt[v]    <= cnt[v] + CNT_W'(wr_sel[v]) - CNT_W'(rd_sel[v]);
      end

  // storage is deliberately left unreset
  always_ff @(posedge clk_i)
    if (wr_ok) mem[wr_vc_i][wr_ptr[wr_vc_i]] <= data_i;

  // rejected requests raise a one-cycle pulse
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= wr_en_i && !wr_ok;
      underflow_o <= rd_en_i && !rd_ok;
    end

`ifdef VC_FIFO_FWFT_EN
  assign data_o  = mem[rd_vc_i][rd_ptr[rd_vc_i]];
  assign valid_o = rd_in && !empty_o[rd_vc_i];
`else
  // registered read path: data appears one cycle after an accepted pop and holds otherwise
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= rd_ok;
      if (rd_ok) data_o <= mem[rd_vc_i][rd_ptr[rd_vc_i]];
    end
`endif
endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: directed table-driven checks of vc_fifo in its registered-read build
module tb_vc_fifo;
  logic       clk = 1'b0, rst_i = 1'b1;
  logic       wr_en_i = 0, wr_vc_i = 0, rd_en_i = 0, rd_vc_i = 0;
  logic [7:0] data_i = 0, data_o;
  logic       valid_o, overflow_o, underflow_o;
  logic [1:0] full_o, empty_o;
  logic [5:0] count_o;
  int         pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  vc_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH_WIDTH(2), .NUM_VC(2), .ID(0)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_vc_i(wr_vc_i), .data_i(data_i),
    .rd_en_i(rd_en_i), .rd_vc_i(rd_vc_i), .data_o(data_o), .valid_o(valid_o),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o));

  typedef struct {
    logic       we, wv;
    logic [7:0] d;
    logic       re, rv;
    logic [7:0] ed;
    logic       ev;
    logic [1:0] ef, ee;
    logic [2:0] c0, c1;
    logic       eo, eu;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic we, logic wv, logic [7:0] d, logic re, logic rv,
                              logic [7:0] ed, logic ev, logic [1:0] ef, logic [1:0] ee,
                              logic [2:0] c0, logic [2:0] c1, logic eo, logic eu);
    vec_t x;
    x.we = we; x.wv = wv; x.d = d; x.re = re; x.rv = rv; x.ed = ed; x.ev = ev;
    x.ef = ef; x.ee = ee; x.c0 = c0; x.c1 = c1; x.eo = eo; x.eu = eu;
    vecs.push_back(x);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic chk_all(int idx, logic [7:0] ed, logic ev, logic [1:0] ef, logic [1:0] ee,
                         logic [2:0] c0, logic [2:0] c1, logic eo, logic eu);
    chk("data", idx, 32'(data_o), 32'(ed));
    chk("valid", idx, 32'(valid_o), 32'(ev));
    chk("full", idx, 32'(full_o), 32'(ef));
    chk("empty", idx, 32'(empty_o), 32'(ee));
    chk("count", idx, 32'(count_o), 32'({c1, c0}));
    chk("overflow", idx, 32'(overflow_o), 32'(eo));
    chk("underflow", idx, 32'(underflow_o), 32'(eu));
  endtask

  task automatic drive(logic we, logic wv, logic [7:0] d, logic re, logic rv);
    wr_en_i = we; wr_vc_i = wv; data_i = d; rd_en_i = re; rd_vc_i = rv;
    @(posedge clk);
    #1;
    wr_en_i = 0; rd_en_i = 0;
  endtask

  initial begin
    //   we wv d      re rv  ed     ev ef     ee     c0 c1 eo eu
    add(1, 0, 8'h11, 0, 0, 8'h00, 0, 2'b00, 2'b10, 1, 0, 0, 0);
    add(1, 0, 8'h22, 0, 0, 8'h00, 0, 2'b00, 2'b10, 2, 0, 0, 0);
    add(1, 0, 8'h33, 0, 0, 8'h00, 0, 2'b00, 2'b10, 3, 0, 0, 0);
    add(1, 0, 8'h44, 0, 0, 8'h00, 0, 2'b01, 2'b10, 4, 0, 0, 0);
    add(1, 0, 8'h55, 0, 0, 8'h00, 0, 2'b01, 2'b10, 4, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 0, 2'b01, 2'b10, 4, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h11, 1, 2'b00, 2'b10, 3, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h22, 1, 2'b00, 2'b10, 2, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h33, 1, 2'b00, 2'b10, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h44, 1, 2'b00, 2'b11, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 8'h44, 0, 2'b00, 2'b11, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'h44, 0, 2'b00, 2'b11, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 8'h44, 0, 2'b00, 2'b11, 0, 0, 0, 0);
    add(1, 0, 8'h11, 0, 0, 8'h44, 0, 2'b00, 2'b10, 1, 0, 0, 0);
    add(1, 0, 8'h22, 0, 0, 8'h44, 0, 2'b00, 2'b10, 2, 0, 0, 0);
    add(1, 0, 8'h33, 0, 0, 8'h44, 0, 2'b00, 2'b10, 3, 0, 0, 0);
    add(1, 0, 8'h44, 0, 0, 8'h44, 0, 2'b01, 2'b10, 4, 0, 0, 0);
    add(1, 0, 8'h66, 1, 0, 8'h11, 1, 2'b01, 2'b10, 4, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h22, 1, 2'b00, 2'b10, 3, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h33, 1, 2'b00, 2'b10, 2, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h44, 1, 2'b00, 2'b10, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h66, 1, 2'b00, 2'b11, 0, 0, 0, 0);
    add(1, 0, 8'hA0, 0, 0, 8'h66, 0, 2'b00, 2'b10, 1, 0, 0, 0);
    add(1, 1, 8'hB0, 0, 0, 8'h66, 0, 2'b00, 2'b00, 1, 1, 0, 0);
    add(1, 0, 8'hA1, 0, 0, 8'h66, 0, 2'b00, 2'b00, 2, 1, 0, 0);
    add(1, 1, 8'hB1, 0, 0, 8'h66, 0, 2'b00, 2'b00, 2, 2, 0, 0);
    add(1, 1, 8'hB2, 1, 0, 8'hA0, 1, 2'b00, 2'b00, 1, 3, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'hB0, 1, 2'b00, 2'b00, 1, 2, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'hA1, 1, 2'b00, 2'b01, 0, 2, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'hB1, 1, 2'b00, 2'b01, 0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'hB2, 1, 2'b00, 2'b11, 0, 0, 0, 0);
    add(1, 1, 8'hC3, 1, 1, 8'hB2, 0, 2'b00, 2'b01, 0, 1, 0, 1);
    add(0, 0, 8'h00, 1, 1, 8'hC3, 1, 2'b00, 2'b11, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    chk_all(-1, 8'h00, 0, 2'b00, 2'b11, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wv, vecs[i].d, vecs[i].re, vecs[i].rv);
      chk_all(i, vecs[i].ed, vecs[i].ev, vecs[i].ef, vecs[i].ee,
              vecs[i].c0, vecs[i].c1, vecs[i].eo, vecs[i].eu);
    end

    drive(1, 0, 8'h01, 0, 0);
    drive(1, 0, 8'h02, 0, 0);
    drive(1, 0, 8'h03, 0, 0);
    drive(1, 0, 8'h04, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk_all(100, 8'h01, 1, 2'b00, 2'b10, 3, 0, 0, 0);
    #2 rst_i = 1;
    #1;
    chk_all(101, 8'h00, 0, 2'b00, 2'b11, 0, 0, 0, 0);
    @(negedge clk);
    rst_i = 0;
    drive(1, 0, 8'h77, 0, 0);
    chk_all(102, 8'h00, 0, 2'b00, 2'b10, 1, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk_all(103, 8'h77, 1, 2'b00, 2'b11, 0, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk_all(104, 8'h77, 0, 2'b00, 2'b11, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
